mem_port_arbiter: RTL and testbench

- Shares the single memory port of axi_interface between the instruction-fetch requester (F stage) and the load/store requester (M stage) of the pipelined MIPS core.
- Replaces the ad-hoc fetch/data select in the top level with a registered arbitration FSM, per-requester ready pulses, held read data, flush-aware data cancellation and a starvation guard for fetch.
- Sits between the core's inst/data SRAM-style request signals and the mem_* port of axi_interface.

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the two core-side SRAM-style requesters (fetch "i_*", load/store
//   "d_*", plus the M-stage flush) and the single downstream memory port
//   ("mem_*") that mem_port_arbiter multiplexes between them.
//
//   modport master : the arbiter's view (takes requests, drives mem_*)
//   modport slave  : the environment's view (core requesters + memory side)
//
//   Signals:
//     i_req/i_addr            fetch request (held until i_ready)
//     i_ready/i_rdata         fetch completion pulse / held fetched word
//     d_req/d_write/d_size/
//     d_wen/d_addr/d_wdata    load/store request (held until d_ready or flush)
//     d_ready/d_rdata         data completion pulse / held load data
//     flush                   exception flush from the M stage
//     mem_a/mem_access/mem_write/mem_size/mem_sel/mem_st_data/mem_flush
//                             downstream request attributes
//     mem_ready/mem_data      downstream completion pulse and read data
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_write;
    logic [1:0]        d_size;
    logic [3:0]        d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;

    logic              flush;

    logic [ADDR_W-1:0] mem_a;
    logic              mem_access;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic [3:0]        mem_sel;
    logic [31:0]       mem_st_data;
    logic              mem_flush;
    logic              mem_ready;
    logic [31:0]       mem_data;

    modport master (
        input  i_req, i_addr,
        output i_ready, i_rdata,
        input  d_req, d_write, d_size, d_wen, d_addr, d_wdata,
        output d_ready, d_rdata,
        input  flush,
        output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data, mem_flush,
        input  mem_ready, mem_data
    );

    modport slave (
        output i_req, i_addr,
        input  i_ready, i_rdata,
        output d_req, d_write, d_size, d_wen, d_addr, d_wdata,
        input  d_ready, d_rdata,
        output flush,
        input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data, mem_flush,
        output mem_ready, mem_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single memory port of axi_interface between the MIPS core's
//   instruction-fetch requester and its load/store requester.
//
//   - Registered arbitration: a request seen in IDLE produces mem_access on
//     the following cycle with all mem_* attributes latched and held stable.
//   - Data normally wins; after STARVE_LIMIT consecutive losses by a pending
//     fetch, fetch is forced to win the next arbitration.
//   - Completion: mem_data is captured into the winner's rdata register and
//     the winner's ready pulses for one cycle (that cycle is also the
//     mandatory IDLE gap between downstream transactions).
//   - A flush during a data access lets the downstream transfer finish
//     (DRAIN) but suppresses d_ready and leaves d_rdata untouched.
//     A flush during a fetch has no effect on the fetch.
//
//   Ports:
//     clk      clock
//     aresetn  synchronous, active-low reset (abandons any transfer)
//     bus      mem_port_arbiter_if.master (core requesters + mem_* port)
//
//   Parameters:
//     STARVE_LIMIT  fetch losses before fetch is forced to win (1..15)
//     ADDR_W        address width
//
//   Optional build macro MEM_ARB_KSEG_XLATE_EN:
//     defined   : kseg0/kseg1 addresses (bit 31 set) have bits [31:29]
//                 cleared on mem_a; data addresses 0xbfaf_xxxx map to
//                 0x1faf_xxxx (takes precedence). Requires ADDR_W = 32.
//     undefined : mem_a carries the raw requester address.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                  clk,
    input  logic                  aresetn,
    mem_port_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INST  = 2'b01,
        ST_DATA  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

`ifdef MEM_ARB_KSEG_XLATE_EN
    // Unmapped kernel segments: strip the segment bits to get the physical address.
    function automatic logic [ADDR_W-1:0] xlate_inst(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] p;
        if (a[31]) begin
            p = {3'b000, a[28:0]};
        end else begin
            p = a;
        end
        return p;
    endfunction

    // Confreg window 0xbfaf_xxxx is remapped first; everything else as fetch.
    function automatic logic [ADDR_W-1:0] xlate_data(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] p;
        if (a[31:16] == 16'hbfaf) begin
            p = {16'h1faf, a[15:0]};
        end else begin
            p = xlate_inst(a);
        end
        return p;
    endfunction
`else
    function automatic logic [ADDR_W-1:0] xlate_inst(input logic [ADDR_W-1:0] a);
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] xlate_data(input logic [ADDR_W-1:0] a);
        return a;
    endfunction
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_cnt_nxt;

    logic              r_i_ready;
    logic              w_i_ready_nxt;
    logic [31:0]       r_i_rdata;
    logic [31:0]       w_i_rdata_nxt;
    logic              r_d_ready;
    logic              w_d_ready_nxt;
    logic [31:0]       r_d_rdata;
    logic [31:0]       w_d_rdata_nxt;

    logic [ADDR_W-1:0] r_mem_a;
    logic [ADDR_W-1:0] w_mem_a_nxt;
    logic              r_mem_access;
    logic              w_mem_access_nxt;
    logic              r_mem_write;
    logic              w_mem_write_nxt;
    logic [1:0]        r_mem_size;
    logic [1:0]        w_mem_size_nxt;
    logic [3:0]        r_mem_sel;
    logic [3:0]        w_mem_sel_nxt;
    logic [31:0]       r_mem_st_data;
    logic [31:0]       w_mem_st_data_nxt;

    logic              w_data_wins;

    // Data wins unless it is being flushed or fetch has lost too often.
    assign w_data_wins = bus.d_req & ~bus.flush & (r_starve_cnt < LIMIT_C);

    // Next-state, starvation counter and next values of every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_starve_cnt_nxt  = r_starve_cnt;
        w_i_ready_nxt     = 1'b0;
        w_d_ready_nxt     = 1'b0;
        w_i_rdata_nxt     = r_i_rdata;
        w_d_rdata_nxt     = r_d_rdata;
        w_mem_a_nxt       = r_mem_a;
        w_mem_access_nxt  = r_mem_access;
        w_mem_write_nxt   = r_mem_write;
        w_mem_size_nxt    = r_mem_size;
        w_mem_sel_nxt     = r_mem_sel;
        w_mem_st_data_nxt = r_mem_st_data;

        case (r_state)
            ST_IDLE: begin
                // mem_ready arriving here belongs to nobody and is ignored.
                w_mem_access_nxt = 1'b0;
                if (w_data_wins) begin
                    w_state_nxt       = ST_DATA;
                    w_mem_access_nxt  = 1'b1;
                    w_mem_a_nxt       = xlate_data(bus.d_addr);
                    w_mem_write_nxt   = bus.d_write;
                    w_mem_size_nxt    = bus.d_size;
                    w_mem_sel_nxt     = bus.d_wen;
                    w_mem_st_data_nxt = bus.d_wdata;
                    // Only a waiting fetch counts as a loss; cannot exceed the limit here.
                    if (bus.i_req) begin
                        w_starve_cnt_nxt = r_starve_cnt + 4'd1;
                    end else begin
                        w_starve_cnt_nxt = r_starve_cnt;
                    end
                end else if (bus.i_req) begin
                    w_state_nxt      = ST_INST;
                    w_mem_access_nxt = 1'b1;
                    w_mem_a_nxt      = xlate_inst(bus.i_addr);
                    w_mem_write_nxt  = 1'b0;
                    w_mem_size_nxt   = 2'b10;
                    w_mem_sel_nxt    = 4'b1111;
                    w_starve_cnt_nxt = 4'd0;
                end else begin
                    // Nothing to grant; a flushed data request is simply dropped.
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_INST: begin
                // Flush does not affect an in-flight fetch.
                if (bus.mem_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_mem_access_nxt = 1'b0;
                    w_i_rdata_nxt    = bus.mem_data;
                    w_i_ready_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_INST;
                end
            end

            ST_DATA: begin
                if (bus.mem_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_mem_access_nxt = 1'b0;
                    // A flush coinciding with completion still cancels the result.
                    if (bus.flush) begin
                        w_d_ready_nxt = 1'b0;
                    end else begin
                        w_d_rdata_nxt = bus.mem_data;
                        w_d_ready_nxt = 1'b1;
                    end
                end else if (bus.flush) begin
                    // Downstream cannot be aborted: keep mem_access up and drain it.
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DRAIN: begin
                if (bus.mem_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_mem_access_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end

            default: begin
                w_state_nxt      = ST_IDLE;
                w_mem_access_nxt = 1'b0;
            end
        endcase
    end

    // Arbitration state and fetch-starvation counter.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // Registered requester-side and downstream outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_i_ready     <= 1'b0;
            r_i_rdata     <= 32'd0;
            r_d_ready     <= 1'b0;
            r_d_rdata     <= 32'd0;
            r_mem_a       <= '0;
            r_mem_access  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_size    <= 2'b10;
            r_mem_sel     <= 4'b1111;
            r_mem_st_data <= 32'd0;
        end else begin
            r_i_ready     <= w_i_ready_nxt;
            r_i_rdata     <= w_i_rdata_nxt;
            r_d_ready     <= w_d_ready_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_mem_a       <= w_mem_a_nxt;
            r_mem_access  <= w_mem_access_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_size    <= w_mem_size_nxt;
            r_mem_sel     <= w_mem_sel_nxt;
            r_mem_st_data <= w_mem_st_data_nxt;
        end
    end

    assign bus.i_ready     = r_i_ready;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_ready     = r_d_ready;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.mem_a       = r_mem_a;
    assign bus.mem_access  = r_mem_access;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_size    = r_mem_size;
    assign bus.mem_sel     = r_mem_sel;
    assign bus.mem_st_data = r_mem_st_data;
    // The downstream port needs the flush in the same cycle, so it bypasses the registers.
    assign bus.mem_flush   = bus.flush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model (one
//   outstanding downstream access, owner, cancel flag, fetch-loss count)
//   predicts every output each cycle; a compare process checks them, and
//   literal expectations pin grant order, latency and held data.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic aresetn;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- address mapping as seen on mem_a ----------------
    function automatic logic [31:0] x_inst(input logic [31:0] a);
`ifdef MEM_ARB_KSEG_XLATE_EN
        if (a >= 32'h8000_0000) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    function automatic logic [31:0] x_data(input logic [31:0] a);
`ifdef MEM_ARB_KSEG_XLATE_EN
        if ((a >> 16) == 32'h0000_bfaf) return 32'h1faf_0000 | (a & 32'h0000_ffff);
`endif
        return x_inst(a);
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_busy;
    bit          m_is_data;
    bit          m_cancel;
    int          m_losses;
    bit          e_i_ready, e_d_ready, e_access, e_write;
    logic [31:0] e_i_rdata, e_d_rdata, e_a, e_st;
    logic [1:0]  e_size;
    logic [3:0]  e_sel;

    task automatic model_step();
        if (!aresetn) begin
            m_busy = 0; m_is_data = 0; m_cancel = 0; m_losses = 0;
            e_i_ready = 0; e_d_ready = 0; e_access = 0; e_write = 0;
            e_i_rdata = 0; e_d_rdata = 0; e_a = 0; e_st = 0;
            e_size = 2'b10; e_sel = 4'b1111;
        end else begin
            e_i_ready = 0;
            e_d_ready = 0;
            if (!m_busy) begin
                if (bus.d_req && !bus.flush && m_losses < LIMIT) begin
                    m_busy = 1; m_is_data = 1; m_cancel = 0;
                    e_a = x_data(bus.d_addr); e_write = bus.d_write;
                    e_size = bus.d_size; e_sel = bus.d_wen; e_st = bus.d_wdata;
                    if (bus.i_req) m_losses = m_losses + 1;
                end else if (bus.i_req) begin
                    m_busy = 1; m_is_data = 0; m_cancel = 0; m_losses = 0;
                    e_a = x_inst(bus.i_addr); e_write = 0;
                    e_size = 2'b10; e_sel = 4'b1111;
                end
            end else if (bus.mem_ready) begin
                m_busy = 0;
                if (!m_is_data) begin
                    e_i_rdata = bus.mem_data; e_i_ready = 1;
                end else if (!m_cancel && !bus.flush) begin
                    e_d_rdata = bus.mem_data; e_d_ready = 1;
                end
            end else if (m_is_data && bus.flush) begin
                m_cancel = 1;
            end
            e_access = m_busy;
        end
    endtask

    // ---------------- monitor bookkeeping ----------------
    logic [31:0] grant_q[$];
    bit          prev_acc = 0;
    bit          g_write;
    logic [3:0]  g_sel;
    logic [31:0] g_st;
    int          n_iready = 0;
    int          n_dready = 0;

    // Model update on each edge, then compare once the DUT outputs have settled.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            check("i_ready",     {31'd0, bus.i_ready},    {31'd0, e_i_ready});
            check("d_ready",     {31'd0, bus.d_ready},    {31'd0, e_d_ready});
            check("i_rdata",     bus.i_rdata,             e_i_rdata);
            check("d_rdata",     bus.d_rdata,             e_d_rdata);
            check("mem_a",       bus.mem_a,               e_a);
            check("mem_access",  {31'd0, bus.mem_access}, {31'd0, e_access});
            check("mem_write",   {31'd0, bus.mem_write},  {31'd0, e_write});
            check("mem_size",    {30'd0, bus.mem_size},   {30'd0, e_size});
            check("mem_sel",     {28'd0, bus.mem_sel},    {28'd0, e_sel});
            check("mem_st_data", bus.mem_st_data,         e_st);
            check("mem_flush",   {31'd0, bus.mem_flush},  {31'd0, bus.flush});
            if (bus.mem_access === 1'b1 && !prev_acc) begin
                grant_q.push_back(bus.mem_a);
                g_write = bus.mem_write; g_sel = bus.mem_sel; g_st = bus.mem_st_data;
            end
            prev_acc = (bus.mem_access === 1'b1);
            if (bus.i_ready === 1'b1) n_iready++;
            if (bus.d_ready === 1'b1) n_dready++;
        end
    end

    // ---------------- downstream memory responder ----------------
    int          mem_lat   = 3;
    int          resp_cnt  = 0;
    int          n_resp    = 0;
    int          base_idx  = 0;
    logic [31:0] resp_base = 32'd0;
    bit          stray_req = 0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_access === 1'b1) resp_cnt++;
            else resp_cnt = 0;
            if (resp_cnt == mem_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_data  = resp_base + 32'(n_resp - base_idx);
                n_resp++;
            end else if (stray_req) begin
                bus.mem_ready = 1'b1;
                bus.mem_data  = 32'hFFFF_0000;
                stray_req     = 0;
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic set_resp(input logic [31:0] b);
        resp_base = b;
        base_idx  = n_resp;
    endtask

    // ---------------- requesters ----------------
    task automatic do_fetch(input logic [31:0] a);
        bit got = 0;
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.i_ready === 1'b1) got = 1;
        end
        bus.i_req = 1'b0;
        check("fetch_done", {31'd0, got}, 32'd1);
    endtask

    task automatic do_data(input bit wr, input logic [1:0] sz, input logic [3:0] wen,
                           input logic [31:0] a, input logic [31:0] wd, input bit keep);
        bit got = 0;
        bus.d_write = wr; bus.d_size = sz; bus.d_wen = wen;
        bus.d_addr  = a;  bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (bus.d_ready === 1'b1) got = 1;
        end
        if (!keep) bus.d_req = 1'b0;
        check("data_done", {31'd0, got}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    function automatic logic [31:0] gq(input int i);
        if (i < grant_q.size()) return grant_q[i];
        return 32'hDEAD_DEAD;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int          ni, nd;
        logic [31:0] exp_g[6];

        aresetn = 1'b0;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_write = 0; bus.d_size = 2'b10; bus.d_wen = 4'hF;
        bus.d_addr = 0; bus.d_wdata = 0; bus.flush = 0;
        idle(3);
        check("rst_access", {31'd0, bus.mem_access}, 32'd0);
        check("rst_size",   {30'd0, bus.mem_size},   32'd2);
        check("rst_sel",    {28'd0, bus.mem_sel},    32'hF);
        check("rst_rdata",  bus.i_rdata,             32'd0);
        aresetn = 1'b1;
        idle(2);

        // Fetch only: one-cycle request-to-access latency.
        set_resp(32'h2408_0001);
        grant_q.delete();
        ni = n_iready;
        bus.i_addr = 32'hBFC0_0000;
        bus.i_req  = 1'b1;
        @(negedge clk);
        check("fetch_latency", {31'd0, bus.mem_access}, 32'd1);
        do_fetch(32'hBFC0_0000);
        idle(3);
        check("fetch_rdata",  bus.i_rdata,        32'h2408_0001);
        check("fetch_pulses", 32'(n_iready - ni), 32'd1);
`ifdef MEM_ARB_KSEG_XLATE_EN
        check("fetch_addr", gq(0), 32'h1FC0_0000);
`else
        check("fetch_addr", gq(0), 32'hBFC0_0000);
`endif

        // Simultaneous requests: data first, fetch after the idle cycle.
        set_resp(32'h0000_0100);
        grant_q.delete();
        fork
            do_data(1'b0, 2'b10, 4'hF, 32'h8000_1000, 32'd0, 1'b0);
            do_fetch(32'h0040_0000);
        join
        idle(3);
`ifdef MEM_ARB_KSEG_XLATE_EN
        check("simul_first", gq(0), 32'h0000_1000);
`else
        check("simul_first", gq(0), 32'h8000_1000);
`endif
        check("simul_second", gq(1),       32'h0040_0000);
        check("simul_drdata", bus.d_rdata, 32'h0000_0100);
        check("simul_irdata", bus.i_rdata, 32'h0000_0101);

        // Starvation guard: four data wins, then fetch is forced through.
        set_resp(32'h0000_0200);
        grant_q.delete();
        fork
            for (int n = 0; n < 5; n++)
                do_data(1'b0, 2'b10, 4'hF, 32'h0000_2000 + 32'(4 * n), 32'd0, n < 4);
            do_fetch(32'h0040_0000);
        join
        idle(3);
        exp_g = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h0040_0000, 32'h2010};
        check("starve_count", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("starve_order", gq(i), exp_g[i]);

        // Store attributes.
        set_resp(32'h1111_2222);
        grant_q.delete();
        nd = n_dready;
        do_data(1'b1, 2'b01, 4'b0011, 32'h0000_3000, 32'h0000_BEEF, 1'b0);
        idle(3);
        check("store_write",  {31'd0, g_write},   32'd1);
        check("store_sel",    {28'd0, g_sel},     32'h3);
        check("store_data",   g_st,               32'h0000_BEEF);
        check("store_pulses", 32'(n_dready - nd), 32'd1);
        check("store_rdata",  bus.d_rdata,        32'h1111_2222);

        // Flush one cycle after a data grant: drained, no d_ready.
        set_resp(32'hDEAD_BEEF);
        nd = n_dready;
        bus.d_write = 1'b0; bus.d_addr = 32'h0000_3004; bus.d_req = 1'b1;
        @(negedge clk);
        check("flush_granted", {31'd0, bus.mem_access}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_hold", {31'd0, bus.mem_access}, 32'd1);
        bus.flush = 1'b0;
        bus.d_req = 1'b0;
        for (int k = 0; k < 20 && bus.mem_access === 1'b1; k++) @(negedge clk);
        check("flush_drained", {31'd0, bus.mem_access}, 32'd0);
        idle(3);
        check("flush_pulses", 32'(n_dready - nd), 32'd0);
        check("flush_rdata",  bus.d_rdata,        32'h1111_2222);

        // Stray mem_ready in IDLE, then a flushed request that must be dropped.
        grant_q.delete();
        stray_req = 1;
        idle(3);
        bus.d_addr = 32'h0000_3008; bus.d_req = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.d_req = 1'b0; bus.flush = 1'b0;
        idle(3);
        check("drop_no_grant", 32'(grant_q.size()), 32'd0);

        // Flush during a fetch does not cancel it.
        set_resp(32'h0000_0300);
        ni = n_iready;
        fork
            do_fetch(32'h0040_0040);
            begin
                idle(2);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
        join
        idle(3);
        check("iflush_pulses", 32'(n_iready - ni), 32'd1);
        check("iflush_rdata",  bus.i_rdata,        32'h0000_0300);

        // Reset in the middle of a fetch: abandoned, no i_ready afterwards.
        mem_lat = 100;
        ni = n_iready;
        bus.i_addr = 32'h0040_0080;
        bus.i_req  = 1'b1;
        for (int k = 0; k < 5 && bus.mem_access !== 1'b1; k++) @(negedge clk);
        check("rstmid_active", {31'd0, bus.mem_access}, 32'd1);
        aresetn   = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        check("rstmid_access", {31'd0, bus.mem_access}, 32'd0);
        check("rstmid_a",      bus.mem_a,               32'd0);
        check("rstmid_irdata", bus.i_rdata,             32'd0);
        aresetn = 1'b1;
        mem_lat = 3;
        idle(6);
        check("rstmid_pulses", 32'(n_iready - ni), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
